// File: rtl/synth_pkg.sv
// Shared types and helpers for the synth engine front end.
// Holds the allocator FSM encoding and width utilities.
package synth_pkg;

   typedef enum logic [1:0] {IDLE, SCAN, COMMIT} valloc_state_t;

   localparam logic [7:0] NOTE_OFF_VEL_DEFAULT = 8'd64;

   function automatic int clogb2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/voice_key_table.sv
// Per-voice key register file with one write port.
// Read port at the scan index, compared against the latched key.
module voice_key_table
   import synth_pkg::*;
#(
   parameter int VOICES  = 32,
   parameter int V_WIDTH = clogb2(VOICES)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               we_i,
   input  logic [V_WIDTH-1:0] waddr_i,
   input  logic [7:0]         wdata_i,
   input  logic [V_WIDTH-1:0] raddr_i,
   input  logic [7:0]         key_i,
   output logic               hit_o
);

   logic [7:0] tbl_q [VOICES];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < VOICES; i++) tbl_q[i] <= '0;
      end else if (we_i) begin
         tbl_q[waddr_i] <= wdata_i;
      end
   end

   assign hit_o = (tbl_q[raddr_i] == key_i);

endmodule

// File: rtl/voice_allocator.sv
// Note-event scheduler: maps MIDI note events onto synth voices.
// Priority on note-on is retrigger, then free voice, then round-robin steal.
module voice_allocator
   import synth_pkg::*;
#(
   parameter int VOICES  = 32,
   parameter int V_WIDTH = clogb2(VOICES)
) (
   input  logic               reg_clk,
   input  logic               reset_reg,
   input  logic               ev_valid,
   output logic               ev_ready,
   input  logic               ev_is_on,
   input  logic [7:0]         ev_key,
   input  logic [7:0]         ev_vel,
   input  logic               all_notes_off,
   input  logic [VOICES-1:0]  voice_free,
   output logic [VOICES-1:0]  keys_on,
   output logic               note_on,
   output logic [V_WIDTH-1:0] cur_key_adr,
   output logic [7:0]         cur_key_val,
   output logic [7:0]         cur_vel_on,
   output logic [7:0]         cur_vel_off,
   output logic               steal,
   output logic               unmatched
);

   localparam logic [V_WIDTH-1:0] LAST = V_WIDTH'(VOICES - 1);

   valloc_state_t      state_q;
   logic [V_WIDTH-1:0] idx_q;
   logic [V_WIDTH-1:0] steal_ptr_q;
   logic [V_WIDTH-1:0] match_idx_q;
   logic [V_WIDTH-1:0] free_idx_q;
   logic               match_fnd_q;
   logic               free_fnd_q;
   logic               is_on_q;
   logic [7:0]         key_q;
   logic [7:0]         vel_q;
   logic [VOICES-1:0]  keys_on_q;
   logic               note_on_q;
   logic               steal_q;
   logic               unmatched_q;
   logic [V_WIDTH-1:0] adr_q;
   logic [7:0]         kval_q;
   logic [7:0]         von_q;
   logic [7:0]         voff_q;

   logic               hit;
   logic               do_steal;
   logic [V_WIDTH-1:0] target;
   logic               tbl_we;

   always_comb begin
      do_steal = !match_fnd_q && !free_fnd_q;
      target   = steal_ptr_q;
      if (match_fnd_q)     target = match_idx_q;
      else if (free_fnd_q) target = free_idx_q;
   end

   assign tbl_we = (state_q == COMMIT) && is_on_q && !all_notes_off;

   voice_key_table #(
      .VOICES  (VOICES),
      .V_WIDTH (V_WIDTH)
   ) u_tbl (
      .clk_i   (reg_clk),
      .rst_i   (reset_reg),
      .we_i    (tbl_we),
      .waddr_i (target),
      .wdata_i (key_q),
      .raddr_i (idx_q),
      .key_i   (key_q),
      .hit_o   (hit)
   );

   always_ff @(posedge reg_clk) begin
      if (reset_reg) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         steal_ptr_q <= '0;
         match_idx_q <= '0;
         free_idx_q  <= '0;
         match_fnd_q <= 1'b0;
         free_fnd_q  <= 1'b0;
         is_on_q     <= 1'b0;
         key_q       <= '0;
         vel_q       <= '0;
         keys_on_q   <= '0;
         note_on_q   <= 1'b0;
         steal_q     <= 1'b0;
         unmatched_q <= 1'b0;
         adr_q       <= '0;
         kval_q      <= '0;
         von_q       <= '0;
         voff_q      <= '0;
      end else begin
         note_on_q   <= 1'b0;
         steal_q     <= 1'b0;
         unmatched_q <= 1'b0;
         if (all_notes_off) begin
            keys_on_q <= '0;
            state_q   <= IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  if (ev_valid) begin
                     // zero-velocity note-on is a note-off
                     is_on_q     <= ev_is_on && (ev_vel != 8'd0);
                     key_q       <= ev_key;
                     vel_q       <= ev_vel;
                     idx_q       <= '0;
                     match_fnd_q <= 1'b0;
                     free_fnd_q  <= 1'b0;
                     state_q     <= SCAN;
                  end
               end
               SCAN: begin
                  if (!match_fnd_q && hit && keys_on_q[idx_q]) begin
                     match_fnd_q <= 1'b1;
                     match_idx_q <= idx_q;
                  end
                  if (!free_fnd_q && voice_free[idx_q] && !keys_on_q[idx_q]) begin
                     free_fnd_q <= 1'b1;
                     free_idx_q <= idx_q;
                  end
                  if (idx_q == LAST) state_q <= COMMIT;
                  else idx_q <= idx_q + 1'b1;
               end
               COMMIT: begin
                  state_q <= IDLE;
                  if (is_on_q) begin
                     keys_on_q[target] <= 1'b1;
                     note_on_q         <= 1'b1;
                     steal_q           <= do_steal;
                     adr_q             <= target;
                     kval_q            <= key_q;
                     von_q             <= vel_q;
                     if (do_steal)
                        steal_ptr_q <= (steal_ptr_q == LAST) ? '0 : steal_ptr_q + 1'b1;
                  end else if (match_fnd_q) begin
                     keys_on_q[match_idx_q] <= 1'b0;
                     adr_q                  <= match_idx_q;
                     kval_q                 <= key_q;
                     voff_q                 <= vel_q;
                  end else begin
                     unmatched_q <= 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign ev_ready    = (state_q == IDLE) && !reset_reg && !all_notes_off;
   assign keys_on     = keys_on_q;
   assign note_on     = note_on_q;
   assign steal       = steal_q;
   assign unmatched   = unmatched_q;
   assign cur_key_adr = adr_q;
   assign cur_key_val = kval_q;
   assign cur_vel_on  = von_q;
   assign cur_vel_off = voff_q;

endmodule
